// File: rtl/ram_pkg.sv
// Shared constants and sequencer state encoding for the dual-port RAM
// with built-in fill engine.
package ram_pkg;

    localparam int RDW_OLD       = 0;
    localparam int RDW_NEW       = 1;
    localparam int INIT_ZERO     = 0;
    localparam int INIT_IDENTITY = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ram_init_seq.sv
// Fill sequencer: walks a counter over every word and presents the fill
// pattern to the array, reporting busy while filling and a one-cycle done.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_MODE  = INIT_ZERO
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fill_we,
    output logic [ADDR_WIDTH-1:0] o_fill_addr,
    output logic [DATA_WIDTH-1:0] o_fill_data,
    output seq_state_t            o_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    seq_state_t            r_state;
    seq_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] w_next_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // The counter doubles as the fill address; it only needs to be valid in FILL.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = FILL;
                    w_next_count = '0;
                end
            end
            FILL: begin
                w_next_count = r_count + 1'b1;
                if (r_count == LAST_ADDR) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_busy      = (r_state == FILL);
    assign o_done      = (r_state == DONE);
    assign o_fill_we   = (r_state == FILL);
    assign o_fill_addr = r_count;
    assign o_fill_data = (INIT_MODE == INIT_IDENTITY) ? DATA_WIDTH'(r_count) : '0;
    assign o_state     = r_state;

endmodule

// File: rtl/ram_dp_init.sv
// True dual-port synchronous RAM with selectable read-during-write policy
// and a hardware fill engine (zeros or identity pattern).
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RDW_MODE   = RDW_OLD,
    parameter int INIT_MODE  = INIT_ZERO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  wren_a,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  wren_b,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q_a;
    logic [DATA_WIDTH-1:0] r_q_b;

    logic                  w_fill_we;
    logic [ADDR_WIDTH-1:0] w_fill_addr;
    logic [DATA_WIDTH-1:0] w_fill_data;
    seq_state_t            w_state;
    logic                  w_user;
    logic                  w_in_a;
    logic                  w_in_b;
    logic                  w_we_a;
    logic                  w_we_b;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    ram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_MODE  (INIT_MODE)
    ) u_seq (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_start     (init_start),
        .o_busy      (init_busy),
        .o_done      (init_done),
        .o_fill_we   (w_fill_we),
        .o_fill_addr (w_fill_addr),
        .o_fill_data (w_fill_data),
        .o_state     (w_state)
    );

    // User ports are frozen for the whole fill; DONE behaves like IDLE.
    assign w_user = (w_state != FILL);
    assign w_in_a = (32'(address_a) < DEPTH);
    assign w_in_b = (32'(address_b) < DEPTH);

    // Port A wins a same-address collision, so B's write is suppressed.
    assign w_we_a = w_user && !reset && wren_a && w_in_a;
    assign w_we_b = w_user && !reset && wren_b && w_in_b &&
                    !(w_we_a && (address_a == address_b));

    always_comb begin
        w_rd_a = '0;
        if (w_in_a) begin
            w_rd_a = (RDW_MODE == RDW_NEW && wren_a) ? data_a : r_mem[address_a];
        end
    end

    always_comb begin
        w_rd_b = '0;
        if (w_in_b) begin
            w_rd_b = (RDW_MODE == RDW_NEW && wren_b) ? data_b : r_mem[address_b];
        end
    end

    // No reset on the array: contents survive reset, and an aborted fill
    // must not write the word it was about to reach.
    always_ff @(posedge clock) begin
        if (w_fill_we && !reset) begin
            r_mem[w_fill_addr] <= w_fill_data;
        end
        if (w_we_a) begin
            r_mem[address_a] <= data_a;
        end
        if (w_we_b) begin
            r_mem[address_b] <= data_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q_a <= '0;
            r_q_b <= '0;
        end else if (w_user) begin
            r_q_a <= w_rd_a;
            r_q_b <= w_rd_b;
        end
    end

    assign q_a = r_q_a;
    assign q_b = r_q_b;

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: two instances (identity/old-data/256 words and
// zero/new-data/200 words) driven in lockstep against a per-instance model.
module tb_ram_dp_init;

    logic       clock = 1'b0;
    logic       reset;
    logic       init_start;
    logic [7:0] address_a;
    logic [7:0] data_a;
    logic       wren_a;
    logic [7:0] address_b;
    logic [7:0] data_b;
    logic       wren_b;

    logic [7:0] q_a_o    [2];
    logic [7:0] q_b_o    [2];
    logic       busy_o   [2];
    logic       done_o   [2];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state, one slot per instance.
    int         m_depth [2];
    bit         m_rdw   [2];
    bit         m_ident [2];
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    logic [7:0] m_qa    [2];
    logic [7:0] m_qb    [2];
    bit         m_qak   [2];
    bit         m_qbk   [2];
    bit         m_busy  [2];
    bit         m_done  [2];
    int         m_fill  [2];

    int busy_cnt [2];
    int done_cnt [2];

    always #5 clock = ~clock;

    ram_dp_init #(
        .ADDR_WIDTH (8), .DATA_WIDTH (8), .DEPTH (256), .RDW_MODE (0), .INIT_MODE (1)
    ) u_dut0 (
        .clock (clock), .reset (reset), .init_start (init_start),
        .init_busy (busy_o[0]), .init_done (done_o[0]),
        .address_a (address_a), .data_a (data_a), .wren_a (wren_a), .q_a (q_a_o[0]),
        .address_b (address_b), .data_b (data_b), .wren_b (wren_b), .q_b (q_b_o[0])
    );

    ram_dp_init #(
        .ADDR_WIDTH (8), .DATA_WIDTH (8), .DEPTH (200), .RDW_MODE (1), .INIT_MODE (0)
    ) u_dut1 (
        .clock (clock), .reset (reset), .init_start (init_start),
        .init_busy (busy_o[1]), .init_done (done_o[1]),
        .address_a (address_a), .data_a (data_a), .wren_a (wren_a), .q_a (q_a_o[1]),
        .address_b (address_b), .data_b (data_b), .wren_b (wren_b), .q_b (q_b_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit was_done;
            int ia;
            int ib;
            bit ina;
            bit inb;
            ia  = int'(address_a);
            ib  = int'(address_b);
            ina = (ia < m_depth[d]);
            inb = (ib < m_depth[d]);
            if (reset) begin
                m_qa[d] = 8'h00; m_qak[d] = 1'b1;
                m_qb[d] = 8'h00; m_qbk[d] = 1'b1;
                m_busy[d] = 1'b0; m_done[d] = 1'b0; m_fill[d] = -1;
            end else if (m_fill[d] >= 0) begin
                m_mem[d][m_fill[d]]   = m_ident[d] ? 8'(m_fill[d]) : 8'h00;
                m_known[d][m_fill[d]] = 1'b1;
                m_fill[d]++;
                if (m_fill[d] == m_depth[d]) begin
                    m_fill[d] = -1; m_busy[d] = 1'b0; m_done[d] = 1'b1;
                end
            end else begin
                was_done  = m_done[d];
                m_done[d] = 1'b0;
                if (!was_done && init_start) begin
                    m_busy[d] = 1'b1; m_fill[d] = 0;
                end
                if (!ina) begin
                    m_qa[d] = 8'h00; m_qak[d] = 1'b1;
                end else if (wren_a && m_rdw[d]) begin
                    m_qa[d] = data_a; m_qak[d] = 1'b1;
                end else begin
                    m_qa[d] = m_mem[d][ia]; m_qak[d] = m_known[d][ia];
                end
                if (!inb) begin
                    m_qb[d] = 8'h00; m_qbk[d] = 1'b1;
                end else if (wren_b && m_rdw[d]) begin
                    m_qb[d] = data_b; m_qbk[d] = 1'b1;
                end else begin
                    m_qb[d] = m_mem[d][ib]; m_qbk[d] = m_known[d][ib];
                end
                if (wren_b && inb && !(wren_a && ia == ib)) begin
                    m_mem[d][ib] = data_b; m_known[d][ib] = 1'b1;
                end
                if (wren_a && ina) begin
                    m_mem[d][ia] = data_a; m_known[d][ia] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d init_busy", d), 32'(busy_o[d]), 32'(m_busy[d]));
            check($sformatf("dut%0d init_done", d), 32'(done_o[d]), 32'(m_done[d]));
            if (m_qak[d]) check($sformatf("dut%0d q_a", d), 32'(q_a_o[d]), 32'(m_qa[d]));
            if (m_qbk[d]) check($sformatf("dut%0d q_b", d), 32'(q_b_o[d]), 32'(m_qb[d]));
        end
    endtask

    initial begin
        m_depth  = '{256, 200};
        m_rdw    = '{1'b0, 1'b1};
        m_ident  = '{1'b1, 1'b0};
        m_fill   = '{-1, -1};
        m_qak    = '{1'b0, 1'b0};
        m_qbk    = '{1'b0, 1'b0};
        m_busy   = '{1'b0, 1'b0};
        m_done   = '{1'b0, 1'b0};
        busy_cnt = '{0, 0};
        done_cnt = '{0, 0};
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++) m_known[d][i] = 1'b0;

        reset = 1'b1; init_start = 1'b0;
        address_a = 8'h00; data_a = 8'h00; wren_a = 1'b0;
        address_b = 8'h00; data_b = 8'h00; wren_b = 1'b0;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset q_a", d), 32'(q_a_o[d]), 32'h0);
            check($sformatf("dut%0d reset q_b", d), 32'(q_b_o[d]), 32'h0);
            check($sformatf("dut%0d reset busy", d), 32'(busy_o[d]), 32'h0);
        end
        reset = 1'b0;
        repeat (2) step();

        // Full fill, with a repeated request and user writes while busy.
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        for (int d = 0; d < 2; d++) busy_cnt[d] = int'(busy_o[d]);
        for (int i = 1; i < 270; i++) begin
            init_start = (i == 50);
            wren_a = (i == 180); address_a = 8'd3;   data_a = 8'hEE;
            wren_b = (i == 180); address_b = 8'd150; data_b = 8'hEE;
            step();
            for (int d = 0; d < 2; d++) begin
                busy_cnt[d] += int'(busy_o[d]);
                done_cnt[d] += int'(done_o[d]);
            end
        end
        init_start = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
        check("dut0 busy cycles", 32'(busy_cnt[0]), 32'd256);
        check("dut0 done pulses", 32'(done_cnt[0]), 32'd1);
        check("dut1 busy cycles", 32'(busy_cnt[1]), 32'd200);
        check("dut1 done pulses", 32'(done_cnt[1]), 32'd1);

        address_a = 8'h00; step(); check("identity 0x00", 32'(q_a_o[0]), 32'h00);
        address_a = 8'h7F; step(); check("identity 0x7F", 32'(q_a_o[0]), 32'h7F);
        address_a = 8'hFF; step(); check("identity 0xFF", 32'(q_a_o[0]), 32'hFF);
        address_a = 8'd3; address_b = 8'd150; step();
        check("fill write drop a", 32'(q_a_o[0]), 32'h03);
        check("fill write drop b", 32'(q_b_o[0]), 32'h96);

        // Same-port and cross-port read-during-write.
        address_a = 8'd5; data_a = 8'h11; wren_a = 1'b1; step();
        data_a = 8'h3C; address_b = 8'd5; step();
        wren_a = 1'b0;
        check("rdw old q_a", 32'(q_a_o[0]), 32'h11);
        check("rdw new q_a", 32'(q_a_o[1]), 32'h3C);
        check("rdw old q_b", 32'(q_b_o[0]), 32'h11);
        check("rdw new q_b", 32'(q_b_o[1]), 32'h11);

        // Write collision: port A wins.
        address_a = 8'd9; data_a = 8'h01; wren_a = 1'b1;
        address_b = 8'd9; data_b = 8'h02; wren_b = 1'b1;
        step();
        wren_a = 1'b0; wren_b = 1'b0;
        step();
        check("collision dut0", 32'(q_a_o[0]), 32'h01);
        check("collision dut1", 32'(q_b_o[1]), 32'h01);

        // Out-of-range access on the 200-word instance.
        address_a = 8'd210; data_a = 8'h77; wren_a = 1'b1; step();
        check("oor write q dut1", 32'(q_a_o[1]), 32'h00);
        wren_a = 1'b0; step();
        check("oor read dut1", 32'(q_a_o[1]), 32'h00);

        // Fill aborted by reset on its eleventh cycle.
        for (int i = 0; i <= 10; i++) begin
            address_a = 8'(i); data_a = 8'hA5; wren_a = 1'b1; step();
        end
        wren_a = 1'b0;
        init_start = 1'b1; step(); init_start = 1'b0;
        repeat (10) step();
        reset = 1'b1; step();
        check("abort busy dut0", 32'(busy_o[0]), 32'h0);
        check("abort done dut1", 32'(done_o[1]), 32'h0);
        reset = 1'b0;
        repeat (3) step();
        for (int i = 0; i <= 10; i++) begin
            address_a = 8'(i); step();
            if (i == 9) begin
                check("abort word9 dut0", 32'(q_a_o[0]), 32'h09);
                check("abort word9 dut1", 32'(q_a_o[1]), 32'h00);
            end
            if (i == 10) begin
                check("abort word10 dut0", 32'(q_a_o[0]), 32'hA5);
                check("abort word10 dut1", 32'(q_a_o[1]), 32'hA5);
            end
        end

        // Random traffic, biased toward low addresses for collisions.
        repeat (500) begin
            address_a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            address_b  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            data_a     = 8'($urandom_range(0, 255));
            data_b     = 8'($urandom_range(0, 255));
            wren_a     = ($urandom_range(0, 2) == 0);
            wren_b     = ($urandom_range(0, 2) == 0);
            init_start = ($urandom_range(0, 199) == 0);
            step();
        end
        init_start = 1'b0; wren_a = 1'b0; wren_b = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_init.md
# ram_dp_init

Parametrised true-dual-port synchronous RAM with a built-in initialisation sequencer. It is the next-generation memory model for the lab datapaths, for example the RC4 S-array and key/message stores. Two independent read/write ports share one clock. The read-during-write policy is selectable. A hardware fill engine writes either zeros or the identity pattern (mem[i] = i) into every word, so datapaths no longer need an external init loop.

## Interface
- ADDR_WIDTH, 8, address bits per port
- DATA_WIDTH, 8, word width
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_WIDTH
- RDW_MODE, 0, same-port read-during-write: 0 = old data, 1 = new data
- INIT_MODE, 0, fill pattern: 0 = all zeros, 1 = identity (i truncated to DATA_WIDTH)

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- init_start  in  1  request a fill; sampled only in IDLE
- init_busy  out  1  high while the fill is in progress
- init_done  out  1  one-cycle pulse when the fill completes
- address_a  in  ADDR_WIDTH  port A address
- data_a  in  DATA_WIDTH  port A write data
- wren_a  in  1  port A write enable
- q_a  out  DATA_WIDTH  port A registered read data
- address_b, data_b, wren_b, q_b: same as port A, for port B

## Operation
- Sequencer states: IDLE, FILL, DONE.
  - IDLE -> FILL when init_start = 1; the counter loads 0.
  - FILL writes pattern(counter) to mem[counter] and increments the counter each cycle.
  - FILL -> DONE after the write at counter = DEPTH-1.
  - DONE -> IDLE unconditionally.
- init_start in FILL or DONE is ignored; there is no queuing.
- While in FILL:
  - wren_a and wren_b are ignored; user writes are dropped.
  - q_a and q_b hold their previous values.
- Normal operation (IDLE, DONE):
  - Each port reads mem[address] into q on every cycle.
  - A port writes when its wren is 1.
- Same-port read-during-write:
  - RDW_MODE = 0: q returns the pre-write contents.
  - RDW_MODE = 1: q returns the data being written.
- Cross-port read of an address being written by the other port in the same cycle always returns old data.
- Both ports writing the same address in the same cycle: port A wins; port B's write is dropped.
- Address >= DEPTH: the write is ignored and q returns 0.
- reset:
  - State -> IDLE; counter, q_a, q_b, init_busy and init_done -> 0.
  - Memory contents are NOT cleared.
  - Reset during FILL aborts the fill; words already written keep the pattern, the rest keep their old contents. No init_done pulse is produced.
- reset has priority over init_start in the same cycle.

## Timing
- Read latency is 1 cycle: the address presented before edge k gives q valid after edge k.
- A write at edge k is visible to a read sampled at edge k+1.
- Fill sequence:
  - init_start high at edge k: init_busy = 1 after edge k.
  - Pattern writes occur at edges k+1 … k+DEPTH.
  - After edge k+DEPTH: init_busy = 0 and init_done = 1 for exactly one cycle.
  - The fill takes DEPTH+1 cycles from request to done.
- User accesses issued while init_done = 1 (the DONE state) are honoured normally.
- Reset values: q_a = q_b = 0, init_busy = 0, init_done = 0.

## Structure
- Shared package ram_pkg holds:
  - RDW_OLD/RDW_NEW and INIT_ZERO/INIT_IDENTITY constants
  - the sequencer state encoding (IDLE, FILL, DONE)
- One sub-module, ram_init_seq, contains the FSM, the fill counter (ADDR_WIDTH bits), the pattern generator, and the busy/done outputs. It exposes fill_we, fill_addr and fill_data to the array.
- The top level holds the memory array, the two-port write/read muxing, and the collision and RDW logic.

## Test plan
- Identity fill (INIT_MODE=1, DEPTH=256): pulse init_start -> busy for 256 cycles, then a single done pulse. Reading addr 0x00, 0x7F, 0xFF returns 0x00, 0x7F, 0xFF.
- Fill abort: init_start, then reset at fill cycle 10 -> busy = 0, no done pulse. Words 0-9 hold the pattern; word 10 keeps its prior value (0xA5 preloaded).
- RDW: port A writes 0x3C to addr 5 (prior 0x11) while reading addr 5.
  - RDW_MODE=0: q_a = 0x11; RDW_MODE=1: q_a = 0x3C.
  - In both modes, port B reading addr 5 in the same cycle gets 0x11.
- Write collision: A writes 0x01 and B writes 0x02 to addr 9 in the same cycle -> the next read of addr 9 = 0x01.
- Writes during fill: wren_a = 1 with addr 3, data 0xEE mid-fill -> after done, addr 3 reads pattern(3), not 0xEE.
- Out-of-range access (DEPTH=200): a write to addr 210 leaves memory unchanged; a read of addr 210 returns 0.
